// File: rtl/abz_pkg.sv
// Shared definitions for the ABZ quadrature generator: FSM state encoding and
// the position-to-AB phase mapping used by the output registers.
package abz_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } abz_state_t;

  localparam int ABZ_SYNC_STAGES = 2;

  // Returns {A, B}; forward counting walks AB 00 -> 10 -> 11 -> 01 -> 00.
  function automatic logic [1:0] pos_to_ab(input logic [1:0] pos);
    return {pos[1] ^ pos[0], pos[1]};
  endfunction

endpackage

// File: rtl/abz_gen_if.sv
// Move-command channel of the ABZ generator.
// Valid/ready: the master holds CMD_VALID, TARGET and DIV; a command is taken
// on the rising CLK edge where CMD_VALID and CMD_READY are both high. The slave
// never queues a command offered while CMD_READY is low.
interface abz_gen_if #(
  parameter int BIT_LENGTH = 12,
  parameter int DIV_WIDTH  = 16
);
  logic                  CMD_VALID;
  logic                  CMD_READY;
  logic [BIT_LENGTH-1:0] TARGET;
  logic [DIV_WIDTH-1:0]  DIV;

  modport master (
    output CMD_VALID,
    output TARGET,
    output DIV,
    input  CMD_READY
  );

  modport slave (
    input  CMD_VALID,
    input  TARGET,
    input  DIV,
    output CMD_READY
  );
endinterface

// File: rtl/abz_gen_timer.sv
// Step-period down-counter: load a period, pulse o_tick every period clocks
// while enabled, clear to zero on request.
module abz_gen_timer #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_load,
  input  logic [DIV_WIDTH-1:0] i_period,
  input  logic                 i_en,
  input  logic                 i_clear,
  output logic                 o_tick
);

  logic [DIV_WIDTH-1:0] r_period;
  logic [DIV_WIDTH-1:0] r_cnt;

  // Expiry is the last count of the period, so the edge lands exactly
  // i_period clocks after the load.
  assign o_tick = i_en && (r_cnt == DIV_WIDTH'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period <= '0;
      r_cnt    <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_period <= i_period;
      r_cnt    <= i_period;
    end else if (o_tick) begin
      r_cnt <= r_period;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/abz_gen.sv
// ABZ quadrature encoder emulator: steps an emulated position toward a
// commanded target at a programmable rate and drives registered A/B/Z lines.
module abz_gen
  import abz_pkg::*;
#(
  parameter int BIT_LENGTH = 12,
  parameter int DIV_WIDTH  = 16,
  parameter int Z_POS      = 0
) (
  input  logic                  CLK,
  input  logic                  ARSTN,
  abz_gen_if.slave              cmd,
  input  logic                  ABORT_H,
  input  logic                  EN_INIT_IN,
  input  logic [BIT_LENGTH-1:0] INIT_COUNT,
  output logic                  A_OUT,
  output logic                  B_OUT,
  output logic                  Z_OUT,
  output logic [BIT_LENGTH-1:0] POS_OUT,
  output logic                  DONE_OUT,
  output abz_state_t            STATE_OUT
);

  localparam logic [BIT_LENGTH-1:0] LP_Z = BIT_LENGTH'(Z_POS);

  logic [ABZ_SYNC_STAGES-1:0] r_sync;
  logic                       w_rst_n;

  abz_state_t            r_state;
  logic                  r_ready;
  logic                  r_done;
  logic [BIT_LENGTH-1:0] r_pos;
  logic [BIT_LENGTH-1:0] r_target;
  logic                  r_rev;
  logic                  r_a;
  logic                  r_b;
  logic                  r_z;

  logic                  w_tick;
  logic                  w_accept;
  logic                  w_start;
  logic                  w_step;
  logic                  w_arrive;
  logic                  w_preset;
  logic                  w_timer_clear;
  logic                  w_timer_en;
  logic [BIT_LENGTH-1:0] w_diff;
  logic [BIT_LENGTH-1:0] w_pos_step;
  logic [BIT_LENGTH-1:0] w_pos_nxt;
  logic [DIV_WIDTH-1:0]  w_period;

  // Reset asserts immediately and releases two CLK edges after ARSTN rises.
  always_ff @(posedge CLK or negedge ARSTN) begin
    if (!ARSTN) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[ABZ_SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign w_rst_n = r_sync[ABZ_SYNC_STAGES-1];

  always_comb begin
    w_diff        = cmd.TARGET - r_pos;
    w_period      = (cmd.DIV == '0) ? DIV_WIDTH'(1) : cmd.DIV;
    w_accept      = (r_state == ST_IDLE) && cmd.CMD_VALID;
    w_start       = w_accept && (w_diff != '0);
    w_preset      = (r_state == ST_IDLE) && !cmd.CMD_VALID && EN_INIT_IN;
    w_timer_en    = (r_state == ST_RUN);
    // An abort in the same cycle as a timer tick swallows that edge.
    w_step        = (r_state == ST_RUN) && !ABORT_H && w_tick;
    w_pos_step    = r_rev ? (r_pos - BIT_LENGTH'(1)) : (r_pos + BIT_LENGTH'(1));
    w_arrive      = w_step && (w_pos_step == r_target);
    w_timer_clear = (r_state == ST_RUN) && (ABORT_H || w_arrive);
    w_pos_nxt     = r_pos;
    if (w_step) begin
      w_pos_nxt = w_pos_step;
    end else if (w_preset) begin
      w_pos_nxt = INIT_COUNT;
    end
  end

  abz_gen_timer #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_timer (
    .clk      (CLK),
    .rst_n    (w_rst_n),
    .i_load   (w_start),
    .i_period (w_period),
    .i_en     (w_timer_en),
    .i_clear  (w_timer_clear),
    .o_tick   (w_tick)
  );

  always_ff @(posedge CLK or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state  <= ST_IDLE;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
      r_pos    <= '0;
      r_target <= '0;
      r_rev    <= 1'b0;
      r_a      <= 1'b0;
      r_b      <= 1'b0;
      r_z      <= (LP_Z == '0);
    end else begin
      // Line outputs are derived from the next position so they change
      // in the same cycle as POS_OUT.
      r_pos        <= w_pos_nxt;
      {r_a, r_b}   <= pos_to_ab(w_pos_nxt[1:0]);
      r_z          <= (w_pos_nxt == LP_Z);
      r_done       <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_target <= cmd.TARGET;
            // Half-range distance has MSB set and therefore runs reverse.
            r_rev    <= w_diff[BIT_LENGTH-1];
            r_ready  <= 1'b0;
            if (w_start) begin
              r_state <= ST_RUN;
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (ABORT_H) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
          end else if (w_arrive) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign cmd.CMD_READY = r_ready;
  assign A_OUT         = r_a;
  assign B_OUT         = r_b;
  assign Z_OUT         = r_z;
  assign POS_OUT       = r_pos;
  assign DONE_OUT      = r_done;
  assign STATE_OUT     = r_state;

endmodule

// File: tb/tb_abz_gen.sv
// Directed bench for abz_gen: drivers push expected edges/done pulses into
// queues, a negedge monitor pops and compares them as the DUT produces them.
module tb_abz_gen;
  import abz_pkg::*;

  localparam int BL = 12;
  localparam int DW = 16;
  localparam int ZP = 0;
  localparam int W  = 32 + BL + 3;

  logic          CLK        = 1'b0;
  logic          ARSTN      = 1'b1;
  logic          ABORT_H    = 1'b0;
  logic          EN_INIT_IN = 1'b0;
  logic [BL-1:0] INIT_COUNT = '0;
  logic          A_OUT;
  logic          B_OUT;
  logic          Z_OUT;
  logic [BL-1:0] POS_OUT;
  logic          DONE_OUT;
  abz_state_t    STATE_OUT;

  abz_gen_if #(.BIT_LENGTH(BL), .DIV_WIDTH(DW)) cmd ();

  abz_gen #(
    .BIT_LENGTH (BL),
    .DIV_WIDTH  (DW),
    .Z_POS      (ZP)
  ) dut (
    .CLK        (CLK),
    .ARSTN      (ARSTN),
    .cmd        (cmd),
    .ABORT_H    (ABORT_H),
    .EN_INIT_IN (EN_INIT_IN),
    .INIT_COUNT (INIT_COUNT),
    .A_OUT      (A_OUT),
    .B_OUT      (B_OUT),
    .Z_OUT      (Z_OUT),
    .POS_OUT    (POS_OUT),
    .DONE_OUT   (DONE_OUT),
    .STATE_OUT  (STATE_OUT)
  );

  // Clock and cycle counter
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Scoreboard state
  int            n_total = 0;
  int            n_bad   = 0;
  bit            mon_en  = 1'b0;
  logic [BL-1:0] prev_pos = '0;
  logic [BL-1:0] m_pos    = '0;
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  done_q[$];
  logic [1:0]    ab_tab[4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  // Expected record: {cycle, position, A, B, Z}
  function automatic logic [W-1:0] mk(input int c, input logic [BL-1:0] p);
    logic [1:0] pl;
    logic       z;
    pl = p[1:0];
    z  = (p == BL'(ZP));
    return {32'(c), p, ab_tab[pl], z};
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_reset(input string tag);
    logic z_rst;
    z_rst = (ZP == 0);
    chk({tag, "_pos"},   W'(POS_OUT),       W'(0));
    chk({tag, "_a"},     W'(A_OUT),         W'(1'b0));
    chk({tag, "_b"},     W'(B_OUT),         W'(1'b0));
    chk({tag, "_z"},     W'(Z_OUT),         W'(z_rst));
    chk({tag, "_done"},  W'(DONE_OUT),      W'(1'b0));
    chk({tag, "_ready"}, W'(cmd.CMD_READY), W'(1'b1));
    chk({tag, "_state"}, W'(STATE_OUT),     W'(ST_IDLE));
  endtask

  // Monitor: every position change and every DONE_OUT cycle consumes one entry
  always @(negedge CLK) begin
    if (mon_en) begin
      if (POS_OUT !== prev_pos) begin
        if (exp_q.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL unexpected_edge: got pos %0d at cycle %0d want no edge", POS_OUT, cyc);
        end else begin
          chk("edge", {32'(cyc), POS_OUT, A_OUT, B_OUT, Z_OUT}, exp_q.pop_front());
        end
      end
      if (DONE_OUT) begin
        if (done_q.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL unexpected_done: got DONE_OUT=1 at cycle %0d want 0", cyc);
        end else begin
          chk("done", {32'(cyc), POS_OUT, A_OUT, B_OUT, Z_OUT}, done_q.pop_front());
        end
      end
    end
    prev_pos = POS_OUT;
  end

  // Driver: preset load in IDLE (ABORT_H held high to show it is ignored there)
  task automatic preset(input logic [BL-1:0] v);
    @(negedge CLK);
    EN_INIT_IN = 1'b1;
    INIT_COUNT = v;
    ABORT_H    = 1'b1;
    if (v != m_pos) exp_q.push_back(mk(cyc + 1, v));
    m_pos = v;
    @(negedge CLK);
    EN_INIT_IN = 1'b0;
    ABORT_H    = 1'b0;
    chk("preset_pos", W'(POS_OUT), W'(v));
  endtask

  // Driver: one move. stop_at=0 runs to completion; otherwise abort (or reset
  // when by_reset) is applied on edge stop_at. noise holds EN_INIT_IN high.
  task automatic move(input logic [BL-1:0] tgt, input logic [DW-1:0] dv,
                      input int stop_at, input bit by_reset, input bit noise);
    int            p;
    int            n;
    int            acc;
    int            budget;
    int            k;
    logic [BL-1:0] diff;
    logic [BL-1:0] pos;
    p    = (dv == '0) ? 1 : int'(dv);
    diff = tgt - m_pos;
    n    = diff[BL-1] ? ((1 << BL) - int'(diff)) : int'(diff);
    @(negedge CLK);
    chk("ready_before_cmd", W'(cmd.CMD_READY), W'(1'b1));
    acc = cyc + 1;
    pos = m_pos;
    for (int e = 1; e <= n; e++) begin
      if (stop_at != 0 && (by_reset ? (e > stop_at) : (e >= stop_at))) break;
      pos = diff[BL-1] ? (pos - BL'(1)) : (pos + BL'(1));
      exp_q.push_back(mk(acc + e * p, pos));
    end
    if (stop_at == 0) done_q.push_back(mk(acc + n * p, pos));
    m_pos = by_reset ? '0 : pos;
    cmd.CMD_VALID = 1'b1;
    cmd.TARGET    = tgt;
    cmd.DIV       = dv;
    if (noise) begin
      EN_INIT_IN = 1'b1;
      INIT_COUNT = BL'(12'h555);
    end
    @(negedge CLK);
    cmd.CMD_VALID = (stop_at != 0) && !by_reset;
    cmd.TARGET    = ~tgt;
    cmd.DIV       = DW'(1);
    if (stop_at == 0) begin
      budget = n * p + 8;
      k      = 0;
      while ((exp_q.size() != 0 || done_q.size() != 0 || cmd.CMD_READY !== 1'b1) && k < budget) begin
        @(negedge CLK);
        k++;
      end
      if (k >= budget) begin
        n_total++;
        n_bad++;
        $display("FAIL drain_timeout: got %0d edges/%0d dones pending want 0", exp_q.size(), done_q.size());
        exp_q.delete();
        done_q.delete();
      end
      EN_INIT_IN = 1'b0;
    end else begin
      while (cyc < acc + stop_at * p - 1) @(negedge CLK);
      if (!by_reset) begin
        cmd.CMD_VALID = 1'b0;
        ABORT_H       = 1'b1;
        @(negedge CLK);
        ABORT_H = 1'b0;
        chk("abort_ready", W'(cmd.CMD_READY), W'(1'b1));
        chk("abort_pos",   W'(POS_OUT),       W'(pos));
        chk("abort_state", W'(STATE_OUT),     W'(ST_IDLE));
        repeat (3 * p) @(negedge CLK);
        chk("abort_hold", W'(POS_OUT), W'(pos));
      end else begin
        @(negedge CLK);
        #1;
        mon_en = 1'b0;
        ARSTN  = 1'b0;
        #1;
        chk_reset("rst_mid");
        chk("rst_mid_drop", W'(exp_q.size()), W'(0));
        repeat (3) @(negedge CLK);
        ARSTN = 1'b1;
        repeat (4) @(negedge CLK);
        mon_en = 1'b1;
        repeat (30) @(negedge CLK);
        chk("rst_after_pos",   W'(POS_OUT),       W'(0));
        chk("rst_after_ready", W'(cmd.CMD_READY), W'(1'b1));
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish want finish by t=1000000");
    $fatal(1);
  end

  initial begin
    cmd.CMD_VALID = 1'b0;
    cmd.TARGET    = '0;
    cmd.DIV       = '0;
    #2 ARSTN = 1'b0;
    repeat (3) @(negedge CLK);
    chk_reset("por");
    ARSTN = 1'b1;
    repeat (4) @(negedge CLK);
    chk("por_release_state", W'(STATE_OUT), W'(ST_IDLE));
    mon_en = 1'b1;

    move(BL'(4), DW'(10), 0, 1'b0, 1'b1);
    preset(BL'(0));
    move(BL'(4095), DW'(1), 0, 1'b0, 1'b0);
    preset(BL'(4090));
    move(BL'(5), DW'(0), 0, 1'b0, 1'b0);
    preset(BL'(0));
    move(BL'(2048), DW'(1), 0, 1'b0, 1'b0);
    preset(BL'(0));
    move(BL'(0), DW'(3), 0, 1'b0, 1'b0);
    move(BL'(100), DW'(5), 3, 1'b0, 1'b0);
    move(BL'(5), DW'(3), 0, 1'b0, 1'b0);
    preset(BL'(0));
    move(BL'(200), DW'(2), 50, 1'b1, 1'b0);

    repeat (5) @(negedge CLK);
    chk("queues_empty", W'(exp_q.size() + done_q.size()), W'(0));
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
